// File: rtl/secp256k1_pkg.sv
// secp256k1 field constants, point_decompress state encoding and error bit indices.
// PT_DECOMP_CHECK_EN selects the on-curve check build (adds one CHECK cycle).
package secp256k1_pkg;

  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] CURVE_B = 256'd7;
  // (p+1)/4: p = 3 mod 4, so rhs^EXP_SQRT is a square root whenever one exists
  localparam logic [255:0] EXP_SQRT =
      256'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_BFFFFF0C;
  // 2^256 mod p, used to fold the high half of a product back down
  localparam logic [32:0] RED_C = 33'h1_000003D1;
  localparam int unsigned EXP_TOP = 252;

`ifdef PT_DECOMP_CHECK_EN
  localparam int unsigned DECOMP_LATENCY = 503;
`else
  localparam int unsigned DECOMP_LATENCY = 502;
`endif

  localparam int unsigned ERR_RANGE = 0;
  localparam int unsigned ERR_CURVE = 1;

  typedef enum logic [2:0] {
    StIdle,
    StX2,
    StX3,
    StExp,
    StCheck,
    StFix,
    StDone
  } decomp_state_e;

endpackage

// File: rtl/mod_mult.sv
// Combinational a*b mod p using the sparse secp256k1 modulus (2^256 = 2^32+977 mod p).
module mod_mult
  import secp256k1_pkg::*;
(
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] r
);

  logic [511:0] prod;
  logic [289:0] f1;
  logic [256:0] f2;
  logic [255:0] f3;

  // Two folds bring the value below 2^256 + 2^67; the third cannot carry again,
  // leaving at most one subtraction of p.
  always_comb begin
    prod = {256'd0, a} * {256'd0, b};
    f1   = 290'(prod[255:0]) + 290'(prod[511:256]) * 290'(RED_C);
    f2   = 257'(f1[255:0]) + 257'(f1[289:256]) * 257'(RED_C);
    f3   = f2[255:0] + (f2[256] ? 256'(RED_C) : 256'd0);
    r    = (f3 >= P) ? (f3 - P) : f3;
  end

endmodule

// File: rtl/mod_sqrt_seq.sv
// Constant-time square-and-multiply over EXP_SQRT bits 252..0; owns the shared mod_mult,
// which external callers use through ext_a/ext_b while the exponent loop is idle.
module mod_sqrt_seq
  import secp256k1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] init,
  input  logic [255:0] rhs,
  input  logic [255:0] ext_a,
  input  logic [255:0] ext_b,
  output logic [255:0] prod,
  output logic [255:0] acc,
  output logic         last
);

  logic         busy_q, busy_d;
  logic         mul_q, mul_d;
  logic [7:0]   bit_q, bit_d;
  logic [255:0] acc_q, acc_d;
  logic [255:0] op_a, op_b;
  logic         advance;

  mod_mult u_mult (
    .a (op_a),
    .b (op_b),
    .r (prod)
  );

  always_comb begin
    op_a    = busy_q ? acc_q : ext_a;
    op_b    = busy_q ? (mul_q ? rhs : acc_q) : ext_b;
    // A bit is finished after its MUL cycle, or after SQ alone when the bit is 0
    advance = busy_q & (mul_q | ~EXP_SQRT[bit_q]);
    last    = advance & (bit_q == 8'd0);

    busy_d = busy_q;
    mul_d  = mul_q;
    bit_d  = bit_q;
    acc_d  = acc_q;
    if (start) begin
      busy_d = 1'b1;
      mul_d  = 1'b0;
      bit_d  = 8'(EXP_TOP);
      acc_d  = init;
    end else if (busy_q) begin
      acc_d = prod;
      mul_d = ~advance;
      if (advance) begin
        if (last) busy_d = 1'b0;
        else      bit_d  = bit_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      bit_q  <= 8'd0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      mul_q  <= mul_d;
      bit_q  <= bit_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mod_sub.sv
// Combinational (a - b) mod p for fully reduced operands.
module mod_sub
  import secp256k1_pkg::*;
(
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] r
);

  logic [256:0] d;

  always_comb begin
    d = {1'b0, a} - {1'b0, b};
    r = d[256] ? (d[255:0] + P) : d[255:0];
  end

endmodule

// File: rtl/point_decompress.sv
// Recovers affine (x, y) on secp256k1 from (x, y parity) with valid/ready on both sides.
// Define PT_DECOMP_CHECK_EN to verify y^2 == x^3+7 and flag non-residue x in out_err[1].
module point_decompress
  import secp256k1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_x,
  input  logic         in_y_odd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_x,
  output logic [255:0] out_y,
  output logic [1:0]   out_err
);

  decomp_state_e state_q, state_d;
  logic [255:0]  x_q, x_d, t_q, t_d, rhs_q, rhs_d, y_q, y_d;
  logic          par_q, par_d;
  logic [1:0]    err_q, err_d;

  logic [255:0]  ext_a, ext_b, prod, acc, rhs_new, y_neg;
  logic [256:0]  rhs_sum;
  logic          seq_start, seq_last;

  mod_sqrt_seq u_sqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (seq_start),
    .init  (rhs_new),
    .rhs   (rhs_q),
    .ext_a (ext_a),
    .ext_b (ext_b),
    .prod  (prod),
    .acc   (acc),
    .last  (seq_last)
  );

  mod_sub u_neg (
    .a (256'd0),
    .b (acc),
    .r (y_neg)
  );

  always_comb begin
    ext_a = x_q;
    ext_b = x_q;
    if (state_q == StX3) begin
      ext_a = t_q;
    end else if (state_q == StCheck) begin
      ext_a = acc;
      ext_b = acc;
    end
    rhs_sum = {1'b0, prod} + {1'b0, CURVE_B};
    rhs_new = (rhs_sum >= {1'b0, P}) ? 256'(rhs_sum - {1'b0, P}) : rhs_sum[255:0];
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    t_d       = t_q;
    rhs_d     = rhs_q;
    y_d       = y_q;
    par_d     = par_q;
    err_d     = err_q;
    seq_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          par_d   = in_y_odd;
          err_d   = 2'b00;
          state_d = StX2;
        end
      end
      StX2: begin
        // Out-of-range x bypasses all arithmetic; FIX then forces y to 0
        if (x_q >= P) begin
          err_d[ERR_RANGE] = 1'b1;
          state_d          = StFix;
        end else begin
          t_d     = prod;
          state_d = StX3;
        end
      end
      StX3: begin
        rhs_d     = rhs_new;
        seq_start = 1'b1;
        state_d   = StExp;
      end
      StExp: begin
        if (seq_last) begin
`ifdef PT_DECOMP_CHECK_EN
          state_d = StCheck;
`else
          state_d = StFix;
`endif
        end
      end
`ifdef PT_DECOMP_CHECK_EN
      StCheck: begin
        if (prod != rhs_q) err_d[ERR_CURVE] = 1'b1;
        state_d = StFix;
      end
`endif
      StFix: begin
        if (err_q != 2'b00)        y_d = '0;
        else if (acc[0] != par_q)  y_d = y_neg;
        else                       y_d = acc;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      t_q     <= '0;
      rhs_q   <= '0;
      y_q     <= '0;
      par_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      t_q     <= t_d;
      rhs_q   <= rhs_d;
      y_q     <= y_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_point_decompress.sv
// Self-checking bench for point_decompress: vector table, model-checked random x, stall and
// mid-operation reset sequences. Honours PT_DECOMP_CHECK_EN for the check build.
`timescale 1ns/1ps
module tb_point_decompress;

  localparam logic [255:0] P  =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX =
      256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY =
      256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
`ifdef PT_DECOMP_CHECK_EN
  localparam int LAT = 503;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT = 502;
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_y_odd = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] in_x = '0;
  logic         in_ready, out_valid;
  logic [255:0] out_x, out_y;
  logic [1:0]   out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  point_decompress dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y_odd  (in_y_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  typedef struct {
    logic [255:0] x;
    logic         par;
    logic [255:0] y;
    logic [1:0]   err;
    int           lat;
  } vec_t;

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] b, input logic [255:0] e);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic logic [255:0] curve_rhs(input logic [255:0] x);
    return (mulmod(mulmod(x, x), x) + 256'd7) % P;
  endfunction

  function automatic logic [255:0] sqrt_exp();
    logic [256:0] pp1;
    pp1 = {1'b0, P} + 257'd1;
    return 256'(pp1 >> 2);
  endfunction

  task automatic ref_model(input logic [255:0] x, input logic par, output logic [255:0] y,
                           output logic [1:0] err, output int lat);
    logic [255:0] rhs, r;
    if (x >= P) begin
      y = '0; err = 2'b01; lat = 2;
      return;
    end
    rhs = curve_rhs(x);
    r   = powmod(rhs, sqrt_exp());
    lat = LAT;
    err = 2'b00;
    if (CHK && mulmod(r, r) != rhs) begin
      y = '0; err = 2'b10;
      return;
    end
    if (r != 0 && r[0] != par) r = P - r;
    y = r;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [255:0] x, input logic par, input bit ack,
                         output logic [255:0] y, output logic [1:0] err, output int lat,
                         output logic [255:0] xo);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    in_x = x; in_y_odd = par; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = ~x; in_y_odd = ~par;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1; lat++;
    end
    y = out_y; err = out_err; xo = out_x;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic check_txn(input string tag, input logic [255:0] x, input logic par,
                           input logic [255:0] ey, input logic [1:0] eerr, input int elat);
    logic [255:0] y, xo;
    logic [1:0]   err;
    int           lat;
    run_txn(x, par, 1'b1, y, err, lat, xo);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_err"}, 256'(err), 256'(eerr));
    chk({tag, "_lat"}, 256'(lat), 256'(elat));
    chk({tag, "_x"}, xo, x);
  endtask

  initial begin
    vec_t         tbl[4];
    logic [255:0] rx, ey, y, xo, snap_y, snap_x, nx;
    logic [1:0]   eerr, err;
    int           elat, lat;
    logic         rp, stable;

    tbl[0] = '{GX, 1'b0, GY, 2'b00, LAT};
    tbl[1] = '{GX, 1'b1, P - GY, 2'b00, LAT};
    tbl[2] = '{P, 1'b0, 256'd0, 2'b01, 2};
    tbl[3] = '{{256{1'b1}}, 1'b1, 256'd0, 2'b01, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_x", out_x, 256'd0);
    chk("rst_out_y", out_y, 256'd0);
    chk("rst_out_err", 256'(out_err), 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      check_txn($sformatf("tbl%0d", i), tbl[i].x, tbl[i].par, tbl[i].y, tbl[i].err, tbl[i].lat);

    // First x whose x^3+7 has no square root
    nx = 256'd1;
    for (int i = 0; i < 64; i++) begin
      rx = curve_rhs(nx);
      if (mulmod(powmod(rx, sqrt_exp()), powmod(rx, sqrt_exp())) != rx) break;
      nx = nx + 256'd1;
    end
    for (int p = 0; p < 2; p++) begin
      ref_model(nx, p[0], ey, eerr, elat);
      check_txn($sformatf("nonres%0d", p), nx, p[0], ey, eerr, elat);
    end

    for (int i = 0; i < 6; i++) begin
      rx = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rp = 1'($urandom);
      ref_model(rx, rp, ey, eerr, elat);
      check_txn($sformatf("rand%0d", i), rx, rp, ey, eerr, elat);
    end

    // Output stall in DONE, then back-to-back second request
    run_txn(GX, 1'b0, 1'b0, y, err, lat, xo);
    chk("stall_y", y, GY);
    snap_y = out_y; snap_x = out_x;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_y !== snap_y || out_x !== snap_x || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_err !== 2'b00)
        stable = 1'b0;
    end
    chk("stall_stable", 256'(stable), 256'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", 256'(in_ready), 256'd1);
    chk("release_out_valid", 256'(out_valid), 256'd0);
    check_txn("b2b", GX, 1'b1, P - GY, 2'b00, LAT);

    // Reset in the middle of the exponentiation
    in_x = GX; in_y_odd = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (202) @(posedge clk);
    #1;
    chk("pre_rst_busy", 256'(in_ready), 256'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'd0);
    chk("midrst_in_ready", 256'(in_ready), 256'd1);
    chk("midrst_out_y", out_y, 256'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_txn("after_rst", GX, 1'b0, GY, 2'b00, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
